// File: rtl/dds_pwm_dac_pkg.sv
// Shared types and helpers for the DDS PWM output stage.
// The offset-binary conversion here is the single definition used by the RTL and the bench model.
package dds_pkg;

  localparam int DDS_MAG_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dds_state_e;

  // Offset-binary duty code: magnitude scaled up to the counter width, then added
  // to or subtracted from mid-scale depending on the half-wave sign.
  function automatic logic [31:0] dds_to_offs(input logic [DDS_MAG_W-1:0] mag,
                                              input logic sym,
                                              input int cnt_w);
    logic [31:0] offs;
    logic [31:0] scaled;
    offs   = 32'd1 << (cnt_w - 1);
    scaled = {24'd0, mag} << (cnt_w - 9);
    return sym ? (offs - scaled) : (offs + scaled);
  endfunction

endpackage

// File: rtl/dds_pwm_dac_if.sv
// Signal bundle between the DDS sample source / observer and the PWM output stage.
interface dds_pwm_dac_if #(parameter int CNT_W = 9);
  import dds_pkg::*;

  logic [DDS_MAG_W-1:0] mag;
  logic                 sym;
  logic                 en;
  logic                 pwm;
  logic                 frame;
  logic [CNT_W-1:0]     duty;
  logic                 running;

  modport master (output mag, sym, en, input pwm, frame, duty, running);
  modport slave  (input mag, sym, en, output pwm, frame, duty, running);
endinterface

// File: rtl/dds_pwm_dac_core.sv
// PWM frame counter, wrap detect and registered comparator.
// The pin lags the counter by one cycle; the counter sits at 0 whenever inactive.
module dds_pwm_core #(parameter int CNT_W = 9) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic [CNT_W-1:0] duty,
  output logic             wrap,
  output logic             pwm
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;

  assign wrap = active && (cnt == CNT_MAX);

  // Leaving for IDLE only happens on a wrap, where cnt+1 is already 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      cnt <= active ? cnt + 1'b1 : '0;
      pwm <= active && (cnt < duty);
    end
  end

endmodule

// File: rtl/dds_pwm_dac.sv
// DDS output stage: converts magnitude/sign into a double-buffered duty code and
// drives a frame-aligned PWM pin with clean run/stop (frames are never truncated).
module dds_pwm_dac
  import dds_pkg::*;
#(
  parameter int CNT_W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  dds_pwm_dac_if.slave bus
);

  localparam logic [CNT_W-1:0] OFFS = {1'b1, {(CNT_W-1){1'b0}}};

  dds_state_e       state, state_nxt;
  logic [CNT_W-1:0] code;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] duty_q;
  logic             frame_q;
  logic             active;
  logic             wrap;
  logic             load;

  assign active = (state != IDLE);
  assign code   = CNT_W'(dds_to_offs(bus.mag, bus.sym, CNT_W));

  // A frame starts on IDLE->RUN entry or on a wrap that continues running;
  // a wrap with en low ends the frame without opening a new one.
  assign load = bus.en && ((state == IDLE) || wrap);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en) state_nxt = RUN;
      RUN:     if (!bus.en) state_nxt = wrap ? IDLE : DRAIN;
      DRAIN:   if (bus.en) state_nxt = RUN;
               else if (wrap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shadow  <= OFFS;
      duty_q  <= OFFS;
      frame_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      shadow  <= code;
      frame_q <= load;
      if (load) duty_q <= shadow;
    end
  end

  dds_pwm_core #(.CNT_W(CNT_W)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (active),
    .duty   (duty_q),
    .wrap   (wrap),
    .pwm    (bus.pwm)
  );

  assign bus.duty    = duty_q;
  assign bus.frame   = frame_q;
  assign bus.running = active;

endmodule

// File: tb/tb_dds_pwm_dac.sv
// Directed bench for dds_pwm_dac: reset, code conversion, duty timing, stop/drain/restart,
// a short DDS-like sample sequence and an asynchronous reset mid-frame.
module tb_dds_pwm_dac;
  import dds_pkg::*;

  localparam int CNT_W = 9;
  localparam int FRAME = 1 << CNT_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dds_pwm_dac_if #(.CNT_W(CNT_W)) bus();

  dds_pwm_dac #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge, like the DDS.
  task automatic step();
    @(negedge clk);
  endtask

  // Called on the negedge of a frame-pulse cycle; walks one frame and returns the
  // number of high pwm samples, optionally changing the DDS sample mid-frame.
  task automatic run_frame(input int chg_at, input logic [7:0] m, input logic s,
                           output int hi);
    int stray;
    stray = 0;
    hi = 0;
    for (int i = 0; i < FRAME; i++) begin
      hi += int'(bus.pwm);
      if (i > 0 && bus.frame) stray++;
      if (i == chg_at) begin
        bus.mag = m;
        bus.sym = s;
      end
      step();
    end
    chk("stray_frame", stray, 0);
    chk("frame_period", int'(bus.frame), 1);
  endtask

  logic [7:0] lv_mag [6] = '{8'h10, 8'h80, 8'hff, 8'h10, 8'h80, 8'hff};
  logic       lv_sym [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  int         lv_exp [6] = '{272, 384, 511, 240, 128, 1};

  initial begin
    int hi, drop, stray, bad;
    int seq [6];

    bus.mag = 8'h00;
    bus.sym = 1'b0;
    bus.en  = 1'b0;

    // Reset values
    step(); step();
    chk("rst_pwm", int'(bus.pwm), 0);
    chk("rst_frame", int'(bus.frame), 0);
    chk("rst_running", int'(bus.running), 0);
    chk("rst_duty", int'(bus.duty), 256);
    rst_n = 1'b1;
    step();
    chk("idle_after_rst", int'(bus.running), 0);

    // Full-scale positive, loaded on IDLE->RUN entry
    bus.mag = 8'hff; bus.sym = 1'b0;
    step();
    bus.en = 1'b1;
    step();
    chk("entry_frame", int'(bus.frame), 1);
    chk("entry_running", int'(bus.running), 1);
    chk("duty_ff_pos", int'(bus.duty), 511);
    // Mid-frame sample change must not disturb the current frame
    run_frame(200, 8'hff, 1'b1, hi);
    chk("hi_511_midchg", hi, 511);
    chk("duty_ff_neg", int'(bus.duty), 1);
    run_frame(100, 8'h00, 1'b0, hi);
    chk("hi_1", hi, 1);
    chk("duty_0_pos", int'(bus.duty), 256);
    run_frame(100, 8'h00, 1'b1, hi);
    chk("hi_256", hi, 256);
    chk("lo_256", FRAME - hi, 256);
    chk("duty_0_neg", int'(bus.duty), 256);

    // Stop at cnt=10: frame completes, then IDLE with no frame pulse
    hi = 0; drop = 0; stray = 0;
    for (int i = 0; i < FRAME; i++) begin
      hi += int'(bus.pwm);
      if (!bus.running) drop++;
      if (i > 0 && bus.frame) stray++;
      if (i == 10) bus.en = 1'b0;
      step();
    end
    chk("stop_hi", hi, 256);
    chk("stop_run_drop", drop, 0);
    chk("stop_stray", stray, 0);
    chk("stop_running", int'(bus.running), 0);
    chk("stop_pwm", int'(bus.pwm), 0);
    chk("stop_frame", int'(bus.frame), 0);
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      if (bus.frame || bus.pwm || bus.running) bad++;
      step();
    end
    chk("idle_quiet", bad, 0);

    // en dropped exactly on the wrap cycle: immediate IDLE, no duty load
    bus.en = 1'b1;
    step();
    chk("restart_frame", int'(bus.frame), 1);
    chk("restart_duty", int'(bus.duty), 256);
    bus.mag = 8'hff; bus.sym = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (i == FRAME - 1) bus.en = 1'b0;
      step();
    end
    chk("wrapstop_running", int'(bus.running), 0);
    chk("wrapstop_frame", int'(bus.frame), 0);
    chk("wrapstop_duty", int'(bus.duty), 256);

    // Restart while draining: no gap, next pulse exactly at the wrap
    bus.en = 1'b1;
    step();
    chk("drain_entry_duty", int'(bus.duty), 511);
    hi = 0; drop = 0; stray = 0;
    for (int i = 0; i < FRAME; i++) begin
      hi += int'(bus.pwm);
      if (!bus.running) drop++;
      if (i > 0 && bus.frame) stray++;
      if (i == 50) bus.en = 1'b0;
      if (i == 200) bus.en = 1'b1;
      step();
    end
    chk("drain_hi", hi, 511);
    chk("drain_run_drop", drop, 0);
    chk("drain_stray", stray, 0);
    chk("drain_wrap_frame", int'(bus.frame), 1);
    chk("drain_wrap_running", int'(bus.running), 1);

    // DDS-like sample per frame across a sign toggle
    for (int k = 0; k < 6; k++) begin
      bus.mag = lv_mag[k];
      bus.sym = lv_sym[k];
      run_frame(-1, 8'h00, 1'b0, hi);
      seq[k] = int'(bus.duty);
      chk("live_duty", seq[k], lv_exp[k]);
      chk("live_model", seq[k], int'(dds_to_offs(lv_mag[k], lv_sym[k], CNT_W)));
    end
    for (int k = 0; k < 3; k++) chk("live_symmetry", seq[k] + seq[k+3], 512);

    // Asynchronous reset mid-frame with duty=300 at cnt=100
    bus.mag = 8'h2c; bus.sym = 1'b0;
    run_frame(-1, 8'h00, 1'b0, hi);
    chk("duty_300", int'(bus.duty), 300);
    for (int i = 0; i < 100; i++) step();
    chk("pre_rst_pwm", int'(bus.pwm), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pwm", int'(bus.pwm), 0);
    chk("midrst_running", int'(bus.running), 0);
    chk("midrst_duty", int'(bus.duty), 256);
    chk("midrst_frame", int'(bus.frame), 0);
    bus.en = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("post_rst_idle", int'(bus.running), 0);
    chk("post_rst_pwm", int'(bus.pwm), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
